// File: rtl/snn_pkg.sv
// Shared constants for the spiking-neuron datapath.
// The neuron and every per-synapse accumulator take their default widths from here.
package snn_pkg;

    localparam int SNN_DATA_WIDTH  = 32;
    localparam int SNN_COUNT_WIDTH = 16;

endpackage : snn_pkg

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for a presynaptic spike level.
// Emits a one-cycle event per low-to-high transition, however long the level is held.
module spike_edge_detect (
    input  logic clk,
    input  logic spike_in,
    output logic spike_event
);

    logic spike_q;

    // Reset loads the current input, which is exactly what a normal cycle does.
    // A level held high across reset release therefore never looks like an edge,
    // so no reset branch is needed here.
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        spike_q <= spike_in;
    end

    assign spike_event = spike_in & ~spike_q;

endmodule : spike_edge_detect

// File: rtl/spike_weight_accumulator.sv
// Per-synapse integrator: each spike edge adds the synaptic weight to a
// saturating unsigned sum and bumps a saturating event counter.
module spike_weight_accumulator
    import snn_pkg::*;
#(
    parameter int DATA_WIDTH  = SNN_DATA_WIDTH,
    parameter int COUNT_WIDTH = SNN_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spike_in,
    input  logic [DATA_WIDTH-1:0]  spike_weight,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic [COUNT_WIDTH-1:0] spike_count,
    output logic                   saturated
);

    logic                spike_event;
    logic [DATA_WIDTH:0] sum;

    spike_edge_detect u_edge (
        .clk         (clk),
        .spike_in    (spike_in),
        .spike_event (spike_event)
    );

    // One extra bit so the carry out of the add is the overflow indicator.
    assign sum = {1'b0, dout} + {1'b0, spike_weight};

    always_ff @(posedge clk) begin
        if (rst) begin
            dout        <= '0;
            spike_count <= '0;
            saturated   <= 1'b0;
        end else if (spike_event) begin
            // Only a true carry clips; landing exactly on all ones is not saturation.
            if (sum[DATA_WIDTH]) begin
                dout      <= '1;
                saturated <= 1'b1;
            end else begin
                dout <= sum[DATA_WIDTH-1:0];
            end

            if (spike_count != '1) begin
                spike_count <= spike_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule : spike_weight_accumulator

// File: tb/tb_spike_weight_accumulator.sv
// Bench for spike_weight_accumulator: three instances (32/16, 8/16, 32/2 widths)
// checked against a behavioural model through an expected-value queue.
module tb_spike_weight_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  spike;
    logic [31:0] weight_a;
    logic [7:0]  weight_b;
    logic [31:0] weight_c;

    logic [31:0] dout_a;
    logic [15:0] count_a;
    logic        sat_a;
    logic [7:0]  dout_b;
    logic [15:0] count_b;
    logic        sat_b;
    logic [31:0] dout_c;
    logic [1:0]  count_c;
    logic        sat_c;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        int          inst;
        logic [31:0] dout;
        logic [15:0] cnt;
        logic        sat;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state per instance
    longint unsigned m_dout[3];
    longint unsigned m_cnt[3];
    bit              m_sat[3];
    bit              m_prev[3];
    int              dw[3] = '{32, 8, 32};
    int              cw[3] = '{16, 16, 2};

    always #5 clk = ~clk;

    spike_weight_accumulator #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .spike_in(spike[0]), .spike_weight(weight_a),
        .dout(dout_a), .spike_count(count_a), .saturated(sat_a)
    );

    spike_weight_accumulator #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .spike_in(spike[1]), .spike_weight(weight_b),
        .dout(dout_b), .spike_count(count_b), .saturated(sat_b)
    );

    spike_weight_accumulator #(.DATA_WIDTH(32), .COUNT_WIDTH(2)) dut_c (
        .clk(clk), .rst(rst), .spike_in(spike[2]), .spike_weight(weight_c),
        .dout(dout_c), .spike_count(count_c), .saturated(sat_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic model_step(input int i, input bit r, input bit s, input longint unsigned w);
        longint unsigned max_d;
        longint unsigned max_c;
        longint unsigned total;
        max_d = (64'd1 << dw[i]) - 64'd1;
        max_c = (64'd1 << cw[i]) - 64'd1;
        if (r) begin
            m_dout[i] = 0;
            m_cnt[i]  = 0;
            m_sat[i]  = 1'b0;
        end else if (s && !m_prev[i]) begin
            total = m_dout[i] + w;
            if (total > max_d) begin
                m_dout[i] = max_d;
                m_sat[i]  = 1'b1;
            end else begin
                m_dout[i] = total;
            end
            if (m_cnt[i] < max_c) m_cnt[i] = m_cnt[i] + 1;
        end
        m_prev[i] = s;
    endtask

    // Drive one cycle, push the model's expectation, compare after the edge.
    task automatic tick(input string tag, input logic r, input logic [2:0] spk,
                        input logic [31:0] wa, input logic [7:0] wb, input logic [31:0] wc);
        exp_t e;
        @(negedge clk);
        rst      = r;
        spike    = spk;
        weight_a = wa;
        weight_b = wb;
        weight_c = wc;
        model_step(0, r, spk[0], wa);
        model_step(1, r, spk[1], wb);
        model_step(2, r, spk[2], wc);
        for (int i = 0; i < 3; i++) begin
            e.tag  = tag;
            e.inst = i;
            e.dout = 32'(m_dout[i]);
            e.cnt  = 16'(m_cnt[i]);
            e.sat  = m_sat[i];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.inst)
                0: begin
                    check({e.tag, "_a_dout"}, 64'(dout_a), 64'(e.dout));
                    check({e.tag, "_a_cnt"}, 64'(count_a), 64'(e.cnt));
                    check({e.tag, "_a_sat"}, 64'(sat_a), 64'(e.sat));
                end
                1: begin
                    check({e.tag, "_b_dout"}, 64'(dout_b), 64'(e.dout));
                    check({e.tag, "_b_cnt"}, 64'(count_b), 64'(e.cnt));
                    check({e.tag, "_b_sat"}, 64'(sat_b), 64'(e.sat));
                end
                default: begin
                    check({e.tag, "_c_dout"}, 64'(dout_c), 64'(e.dout));
                    check({e.tag, "_c_cnt"}, 64'(count_c), 64'(e.cnt));
                    check({e.tag, "_c_sat"}, 64'(sat_c), 64'(e.sat));
                end
            endcase
        end
    endtask

    task automatic do_reset(input string tag);
        tick(tag, 1'b1, 3'b000, 0, 0, 0);
        tick(tag, 1'b1, 3'b000, 0, 0, 0);
    endtask

    // One-cycle pulse on instance sel, then a low cycle with a junk weight.
    task automatic pulse(input string tag, input int sel, input logic [31:0] w);
        logic [2:0] s;
        s = 3'b001 << sel;
        tick(tag, 1'b0, s, w, w[7:0], w);
        tick(tag, 1'b0, 3'b000, 32'd100, 8'd100, 32'd100);
    endtask

    initial begin
        rst      = 1'b1;
        spike    = '0;
        weight_a = '0;
        weight_b = '0;
        weight_c = '0;

        // Reset then single pulse
        do_reset("reset");
        check("reset_dout", 64'(dout_a), 64'd0);
        check("reset_cnt", 64'(count_a), 64'd0);
        tick("single", 1'b0, 3'b001, 32'd5, 8'd0, 32'd0);
        check("single_dout", 64'(dout_a), 64'd5);
        check("single_cnt", 64'(count_a), 64'd1);
        check("single_sat", 64'(sat_a), 64'd0);
        tick("single", 1'b0, 3'b000, 32'd5, 8'd0, 32'd0);

        // Held level counts once
        do_reset("held_rst");
        for (int i = 0; i < 10; i++) tick("held", 1'b0, 3'b001, 32'd3, 8'd0, 32'd0);
        check("held_dout", 64'(dout_a), 64'd3);
        check("held_cnt", 64'(count_a), 64'd1);
        tick("held", 1'b0, 3'b000, 32'd3, 8'd0, 32'd0);
        tick("held", 1'b0, 3'b001, 32'd3, 8'd0, 32'd0);
        check("rehit_dout", 64'(dout_a), 64'd6);
        check("rehit_cnt", 64'(count_a), 64'd2);

        // Weight sampled only on events
        do_reset("wsamp_rst");
        pulse("wsamp", 0, 32'd1);
        pulse("wsamp", 0, 32'd2);
        pulse("wsamp", 0, 32'd4);
        check("wsamp_dout", 64'(dout_a), 64'd7);

        // 8-bit saturation
        do_reset("sat_rst");
        pulse("sat", 1, 32'd250);
        tick("sat", 1'b0, 3'b010, 0, 8'd10, 0);
        check("sat_clip_dout", 64'(dout_b), 64'd255);
        check("sat_clip_flag", 64'(sat_b), 64'd1);
        tick("sat", 1'b0, 3'b000, 0, 8'd10, 0);
        pulse("sat", 1, 32'd1);
        check("sat_hold_dout", 64'(dout_b), 64'd255);
        check("sat_hold_cnt", 64'(count_b), 64'd3);
        check("sat_hold_flag", 64'(sat_b), 64'd1);

        do_reset("exact_rst");
        pulse("exact", 1, 32'd250);
        pulse("exact", 1, 32'd5);
        check("exact_dout", 64'(dout_b), 64'd255);
        check("exact_flag", 64'(sat_b), 64'd0);
        pulse("exact", 1, 32'd0);
        check("exact_w0_flag", 64'(sat_b), 64'd0);
        pulse("exact", 1, 32'd1);
        check("exact_over_flag", 64'(sat_b), 64'd1);

        // Reset priority and held level across release
        pulse("prio_pre", 0, 32'd20);
        tick("prio", 1'b1, 3'b001, 32'd9, 8'd0, 32'd0);
        check("prio_dout", 64'(dout_a), 64'd0);
        check("prio_cnt", 64'(count_a), 64'd0);
        for (int i = 0; i < 3; i++) tick("prio_hold", 1'b0, 3'b001, 32'd9, 8'd0, 32'd0);
        check("prio_hold_cnt", 64'(count_a), 64'd0);
        tick("prio_fall", 1'b0, 3'b000, 32'd9, 8'd0, 32'd0);
        tick("prio_rise", 1'b0, 3'b001, 32'd9, 8'd0, 32'd0);
        check("prio_rise_cnt", 64'(count_a), 64'd1);
        check("prio_rise_dout", 64'(dout_a), 64'd9);
        tick("prio_rise", 1'b0, 3'b000, 32'd9, 8'd0, 32'd0);

        // 2-bit counter saturation, zero weights leave dout alone
        do_reset("cnt_rst");
        pulse("cnt", 2, 32'd7);
        for (int i = 0; i < 4; i++) pulse("cnt", 2, 32'd0);
        check("cnt_sat", 64'(count_c), 64'd3);
        check("cnt_dout", 64'(dout_c), 64'd7);

        // Randomised traffic on all three instances
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [2:0]  s;
            logic [31:0] wa;
            logic [31:0] wc;
            r  = ($urandom_range(0, 39) == 0);
            s  = 3'($urandom);
            wa = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1000));
            wc = 32'($urandom_range(0, 50));
            tick("rand", r, s, wa, 8'($urandom_range(0, 40)), wc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spike_weight_accumulator
